// File: rtl/sincronizador_vga_if.sv
// VGA timing bundle: pixel strobe, raster coordinates, delayed syncs
// and the line/frame start pulses consumed by pixel renderers.
interface sincronizador_vga_if;
    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output pixel_tick, pixel_x, pixel_y,
        output video_on, hsync, vsync,
        output line_start, frame_start
    );

    modport slave (
        input pixel_tick, pixel_x, pixel_y,
        input video_on, hsync, vsync,
        input line_start, frame_start
    );
endinterface

// File: rtl/sincronizador_vga.sv
// VGA raster timing: pixel strobe divider, h/v counters and syncs
// delayed to line up with the registered RGB path.
module sincronizador_vga #(
    parameter int CLK_DIV    = 4,
    parameter int H_DISPLAY  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    sincronizador_vga_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_BEG   = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic vo;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vo: 1'b0};

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [9:0]    x_d;
    logic [9:0]    y_d;
    logic          x_wrap;
    logic          y_wrap;
    logic          ls_q;
    logic          fs_q;
    sync_t         dec_d;
    sync_t         pipe_q [SYNC_DELAY+1];

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        x_wrap = (x_q == X_LAST);
        y_wrap = (y_q == Y_LAST);
        x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = y_wrap ? 10'd0 : y_q + 10'd1;
        end
    end

    // Decode the counter values about to be loaded so stage 0 stays
    // aligned with pixel_x/pixel_y; later stages add one pixel each.
    always_comb begin
        dec_d    = SYNC_IDLE;
        dec_d.hs = ~((x_d >= HS_BEG) && (x_d < HS_END));
        dec_d.vs = ~((y_d >= VS_BEG) && (y_d < VS_END));
        dec_d.vo = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == DIV_LAST);
            ls_q   <= tick_q && x_wrap;
            fs_q   <= tick_q && x_wrap && y_wrap;
            if (tick_q) begin
                x_q       <= x_d;
                y_q       <= y_d;
                pipe_q[0] <= dec_d;
                for (int i = 1; i <= SYNC_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign vga.pixel_tick  = tick_q;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
    assign vga.hsync       = pipe_q[SYNC_DELAY].hs;
    assign vga.vsync       = pipe_q[SYNC_DELAY].vs;
    assign vga.video_on    = pipe_q[SYNC_DELAY].vo;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Bench for sincronizador_vga: several parameter sets share one clock
// and reset, each checked every clk against a raster-arithmetic model.
module tb_sincronizador_vga;
    localparam int N = 6;

    localparam int CD [N] = '{4, 1, 2, 4, 1, 2};
    localparam int SD [N] = '{2, 0, 1, 4, 3, 2};
    localparam int HD [N] = '{640, 12, 12, 12, 12, 8};
    localparam int HF [N] = '{16, 3, 3, 3, 3, 2};
    localparam int HS [N] = '{96, 4, 4, 4, 4, 3};
    localparam int HB [N] = '{48, 5, 5, 5, 5, 3};
    localparam int VD [N] = '{480, 6, 6, 6, 6, 5};
    localparam int VF [N] = '{10, 2, 2, 2, 2, 1};
    localparam int VS [N] = '{2, 2, 2, 2, 2, 2};
    localparam int VB [N] = '{33, 3, 3, 3, 3, 2};

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // k = rising edges since reset release; the pixel count t follows
    // from how many strobes fell strictly before the current clk.
    function automatic obs_t ref_model(
        longint k, int cd, int d,
        int hd, int hf, int hsw, int hb,
        int vd, int vf, int vsw, int vb
    );
        obs_t   o;
        longint ht, vt, t, u, ux, uy;
        logic   prev_tick;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        o.tick = (k >= 1) && ((k % cd) == cd - 1);
        if (cd == 1) t = (k > 0) ? k - 1 : 0;
        else         t = k / cd;
        prev_tick = (k >= 2) && (((k - 1) % cd) == cd - 1);
        o.x  = 10'(t % ht);
        o.y  = 10'((t / ht) % vt);
        o.ls = prev_tick && (t > 0) && (t % ht == 0);
        o.fs = o.ls && (t % (ht * vt) == 0);
        u = t - d;
        if (u >= 1) begin
            ux   = u % ht;
            uy   = (u / ht) % vt;
            o.hs = !((ux >= hd + hf) && (ux < hd + hf + hsw));
            o.vs = !((uy >= vd + vf) && (uy < vd + vf + vsw));
            o.vo = (ux < hd) && (uy < vd);
        end else begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            o.vo = 1'b0;
        end
        return o;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_cfg
        sincronizador_vga_if bus ();

        sincronizador_vga #(
            .CLK_DIV   (CD[g]),
            .H_DISPLAY (HD[g]),
            .H_FP      (HF[g]),
            .H_SYNC    (HS[g]),
            .H_BP      (HB[g]),
            .V_DISPLAY (VD[g]),
            .V_FP      (VF[g]),
            .V_SYNC    (VS[g]),
            .V_BP      (VB[g]),
            .SYNC_DELAY(SD[g])
        ) dut (
            .clk    (clk),
            .reset_n(reset_n),
            .vga    (bus)
        );

        obs_t   exp_q [$];
        longint k = 0;

        // Expectation producer: one entry per clk, reset flushes.
        initial forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                k = 0;
                exp_q.delete();
            end else begin
                k = k + 1;
            end
            exp_q.push_back(ref_model(k, CD[g], SD[g],
                HD[g], HF[g], HS[g], HB[g],
                VD[g], VF[g], VS[g], VB[g]));
        end

        initial forever begin
            obs_t act;
            obs_t exp;
            @(negedge clk);
            act = {bus.pixel_tick, bus.pixel_x, bus.pixel_y,
                   bus.video_on, bus.hsync, bus.vsync,
                   bus.line_start, bus.frame_start};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cfg%0d no_expectation at %0t", g, $time);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display({"FAIL cfg%0d outputs at %0t: got tick=%b x=%0d ",
                              "y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b, expected ",
                              "tick=%b x=%0d y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b"},
                             g, $time,
                             act.tick, act.x, act.y, act.vo, act.hs,
                             act.vs, act.ls, act.fs,
                             exp.tick, exp.x, exp.y, exp.vo, exp.hs,
                             exp.vs, exp.ls, exp.fs);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3600) @(posedge clk);
        for (int r = 0; r < 5; r++) begin
            @(posedge clk);
            #3 reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 reset_n = 1'b1;
            repeat ($urandom_range(300, 2500)) @(posedge clk);
        end
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
